// File: rtl/accel_speed_tracker.sv
// accel_speed_tracker
//   Decimates a 3-axis accelerometer stream, forms the truncated squared
//   magnitude minus gravity, quantises it into a speed level, tracks the
//   maximum level over a sliding history window, and detects "strikes"
//   (an arming level followed by a release level) with a cooldown.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   in_valid     in   1      x/y/z valid this cycle
//   x, y, z      in   W      signed axis acceleration
//   mag_sq       out  2W+2   signed truncated |a|^2 - GRAVITY_SQ
//   level        out  5      quantised speed level 1..LEVELS
//   level_valid  out  1      one-cycle pulse marking a new level
//   max_level    out  5      max level over the last WINDOW entries
//   strike       out  1      one-cycle pulse at strike completion
//   strike_speed out  5      peak level of the last strike
//   state        out  2      0 IDLE, 1 TRACK, 2 COOL
module accel_speed_tracker #(
  parameter int     W             = 16,
  parameter int     TRUNC         = 8,
  parameter int     DECIM         = 8,
  parameter longint GRAVITY_SQ    = 260_000_000,
  parameter int     LEVELS        = 11,
  parameter logic [(LEVELS-1)*32-1:0] THRESH = {
    32'd50_000_000, 32'd40_000_000, 32'd30_000_000, 32'd20_000_000,
    32'd10_000_000, 32'd8_000_000,  32'd6_000_000,  32'd4_000_000,
    32'd2_000_000,  32'd1_000_000},
  parameter int     WINDOW        = 8,
  parameter int     ARM_LEVEL     = 6,
  parameter int     RELEASE_LEVEL = 3,
  parameter int     COOLDOWN      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic signed [W-1:0]   x,
  input  logic signed [W-1:0]   y,
  input  logic signed [W-1:0]   z,
  output logic signed [2*W+1:0] mag_sq,
  output logic [4:0]            level,
  output logic                  level_valid,
  output logic [4:0]            max_level,
  output logic                  strike,
  output logic [4:0]            strike_speed,
  output logic [1:0]            state
);

  localparam int MW = 2*W + 2;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PW = $clog2(WINDOW);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [W-1:0]         TMASK = {W{1'b1}} << TRUNC;
  localparam logic signed [MW-1:0] GSQ   = MW'(GRAVITY_SQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    COOL  = 2'd2
  } state_t;

  // ---------------- magnitude and level ----------------
  logic signed [W-1:0]  xt, yt, zt;
  logic signed [MW-1:0] xe, ye, ze;
  logic signed [MW-1:0] mag_calc;
  logic signed [MW-1:0] thr;
  logic [4:0]           lvl_calc;
  logic [DW-1:0]        dcnt;

  assign xt = x & TMASK;
  assign yt = y & TMASK;
  assign zt = z & TMASK;
  assign xe = MW'(xt);
  assign ye = MW'(yt);
  assign ze = MW'(zt);
  assign mag_calc = xe * xe + ye * ye + ze * ze - GSQ;

  // Scan from the top level down so the smallest qualifying level wins;
  // negative magnitudes fall below every threshold and land on level 1.
  always_comb begin
    lvl_calc = 5'(LEVELS);
    thr      = '0;
    for (int unsigned k = LEVELS - 1; k >= 1; k--) begin
      thr = MW'(THRESH[(k-1)*32 +: 32]);
      if (mag_calc <= thr) lvl_calc = 5'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt        <= '0;
      mag_sq      <= '0;
      level       <= 5'd1;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (in_valid) begin
        if (dcnt == DW'(DECIM - 1)) begin
          dcnt        <= '0;
          mag_sq      <= mag_calc;
          level       <= lvl_calc;
          level_valid <= 1'b1;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  // ---------------- level history ----------------
  logic [4:0]    hist [WINDOW];
  logic [PW-1:0] wptr;
  logic [4:0]    max_calc;

  // The slot at wptr is about to be overwritten by the new level, so it is
  // replaced by the new level rather than read.
  always_comb begin
    max_calc = level;
    for (int unsigned i = 0; i < WINDOW; i++) begin
      if (PW'(i) != wptr && hist[PW'(i)] > max_calc) max_calc = hist[PW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WINDOW; i++) hist[PW'(i)] <= '0;
      wptr      <= '0;
      max_level <= '0;
    end else if (level_valid) begin
      hist[wptr] <= level;
      wptr       <= (wptr == PW'(WINDOW - 1)) ? '0 : wptr + 1'b1;
      max_level  <= max_calc;
    end
  end

  // ---------------- strike FSM ----------------
  state_t        st, nxt_st;
  logic [4:0]    peak, nxt_peak;
  logic [CW-1:0] cool_cnt, nxt_cool;
  logic          nxt_strike;
  logic [4:0]    nxt_speed;

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      peak         <= '0;
      cool_cnt     <= '0;
      strike       <= 1'b0;
      strike_speed <= '0;
    end else begin
      st           <= nxt_st;
      peak         <= nxt_peak;
      cool_cnt     <= nxt_cool;
      strike       <= nxt_strike;
      strike_speed <= nxt_speed;
    end
  end

  always_comb begin
    nxt_st     = st;
    nxt_peak   = peak;
    nxt_cool   = cool_cnt;
    nxt_strike = 1'b0;
    nxt_speed  = strike_speed;
    if (level_valid) begin
      case (st)
        IDLE: begin
          if (level >= 5'(ARM_LEVEL)) begin
            nxt_st   = TRACK;
            nxt_peak = level;
          end
        end
        TRACK: begin
          if (level <= 5'(RELEASE_LEVEL)) begin
            nxt_strike = 1'b1;
            nxt_speed  = peak;
            nxt_cool   = CW'(COOLDOWN);
            nxt_st     = (COOLDOWN == 0) ? IDLE : COOL;
          end else if (level > peak) begin
            nxt_peak = level;
          end
        end
        COOL: begin
          if (cool_cnt <= CW'(1)) begin
            nxt_cool = '0;
            nxt_st   = IDLE;
          end else begin
            nxt_cool = cool_cnt - 1'b1;
          end
        end
        default: nxt_st = IDLE;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_accel_speed_tracker.sv
module tb_accel_speed_tracker;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] x, y, z;
  logic signed [33:0] mag_sq;
  logic [4:0]         level;
  logic               level_valid;
  logic [4:0]         max_level;
  logic               strike;
  logic [4:0]         strike_speed;
  logic [1:0]         state;

  int n_pass   = 0;
  int n_checks = 0;
  int strike_cnt = 0;
  logic early, lv_ok, lv_after;

  accel_speed_tracker #(
    .W(16), .TRUNC(8), .DECIM(8), .GRAVITY_SQ(260_000_000), .LEVELS(11),
    .WINDOW(8), .ARM_LEVEL(6), .RELEASE_LEVEL(3), .COOLDOWN(16)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .x(x), .y(y), .z(z),
    .mag_sq(mag_sq), .level(level), .level_valid(level_valid),
    .max_level(max_level), .strike(strike), .strike_speed(strike_speed),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (strike === 1'b1) strike_cnt++;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Holds in_valid for 8 accepted cycles (optionally split by a gap of
  // in_valid=0 cycles), then returns at the negedge after the pulse cycle.
  task automatic do_sample(input logic signed [15:0] sx, sy, sz, input int gap);
    x = sx; y = sy; z = sz;
    in_valid = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4 && gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          if (level_valid) early = 1'b1;
        end
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (i < 7 && level_valid) early = 1'b1;
    end
    lv_ok = level_valid;
    in_valid = 1'b0;
    @(negedge clk);
    lv_after = level_valid;
  endtask

  initial begin
    int pulses, first_at, second_at;
    reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; z = '0;
    repeat (3) @(negedge clk);
    check("rst_mag", mag_sq, 0);
    check("rst_level", level, 1);
    check("rst_lv", level_valid, 0);
    check("rst_max", max_level, 0);
    check("rst_strike", strike, 0);
    check("rst_speed", strike_speed, 0);
    check("rst_state", state, 0);
    reset = 1'b0;

    // gravity only, decimation split by in_valid=0 gap
    do_sample(16'sh0000, 16'sh0000, 16'sh0000, 3);
    check("s1_early", early, 0);
    check("s1_lv", lv_ok, 1);
    check("s1_lv_once", lv_after, 0);
    check("s1_mag", mag_sq, -260_000_000);
    check("s1_level", level, 1);
    check("s1_state", state, 0);
    check("s1_max", max_level, 1);

    do_sample(16'sh4000, 16'sh1000, 16'sh0000, 0);
    check("s2_mag", mag_sq, 25_212_672);
    check("s2_level", level, 8);
    check("s2_state", state, 1);
    check("s2_max", max_level, 8);

    do_sample(16'sh4300, 16'sh0000, 16'sh0000, 0);
    check("s3_mag", mag_sq, 34_191_104);
    check("s3_level", level, 9);
    check("s3_state", state, 1);
    check("s3_strike", strike, 0);
    check("s3_max", max_level, 9);

    do_sample(16'sh3F00, 16'sh0500, 16'sh0000, 0);
    check("s4_mag", mag_sq, 1_750_784);
    check("s4_level", level, 2);
    check("s4_strike", strike, 1);
    check("s4_speed", strike_speed, 9);
    check("s4_state", state, 2);
    @(negedge clk);
    check("s4_strike_off", strike, 0);
    check("s4_speed_hold", strike_speed, 9);
    check("s4_strike_cnt", strike_cnt, 1);

    // level-10 samples during cooldown must not arm
    for (int i = 0; i < 16; i++) begin
      do_sample(16'sh4400, 16'sh0000, 16'sh0000, 0);
      check("cool_state", state, (i < 15) ? 2 : 0);
    end
    check("cool_level", level, 10);
    check("cool_mag", mag_sq, 43_038_464);
    check("cool_max", max_level, 10);
    do_sample(16'sh4400, 16'sh0000, 16'sh0000, 0);
    check("rearm_state", state, 1);

    // truncation: both give the same result
    do_sample(16'sh40FF, 16'sh0000, 16'sh0000, 0);
    check("trunc_mag", mag_sq, 8_435_456);
    check("trunc_level", level, 6);
    do_sample(16'sh4000, 16'sh0000, 16'sh0000, 0);
    check("plain_mag", mag_sq, 8_435_456);
    check("plain_level", level, 6);
    check("plain_state", state, 1);

    // window: 11 then eight level-1 samples
    do_sample(16'sh4800, 16'sh0000, 16'sh0000, 0);
    check("w_level", level, 11);
    check("w_max11", max_level, 11);
    for (int i = 0; i < 8; i++) begin
      do_sample(16'sh0000, 16'sh0000, 16'sh0000, 0);
      if (i == 0) begin
        check("w_strike", strike, 1);
        check("w_speed", strike_speed, 11);
      end
      check("w_max", max_level, (i < 7) ? 11 : 1);
    end
    check("w_state", state, 2);
    check("w_strike_cnt", strike_cnt, 2);

    // reset clears everything
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("r2_state", state, 0);
    check("r2_max", max_level, 0);
    check("r2_speed", strike_speed, 0);

    // back-to-back: 16 valid cycles -> two pulses 8 apart
    x = 16'sh4000; y = '0; z = '0;
    in_valid = 1'b1;
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (level_valid) begin
        pulses++;
        if (first_at < 0) first_at = i; else second_at = i;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_pulses", pulses, 2);
    check("b2b_first", first_at, 7);
    check("b2b_second", second_at, 15);
    check("b2b_mag", mag_sq, 8_435_456);
    check("b2b_level", level, 6);
    check("b2b_state", state, 1);
    check("b2b_max", max_level, 6);

    // reset mid-TRACK with a release-level sample pending
    x = '0;
    in_valid = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    check("abort_state", state, 0);
    check("abort_max", max_level, 0);
    check("abort_strike", strike, 0);
    check("abort_level", level, 1);
    check("abort_mag", mag_sq, 0);
    do_sample(16'sh0000, 16'sh0000, 16'sh0000, 0);
    check("abort_early", early, 0);
    check("abort_lv", lv_ok, 1);
    check("abort_idle", state, 0);
    @(negedge clk);
    check("abort_strike_cnt", strike_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
